// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the async_fifo write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

    // PTR_W = clog2(N); at least one bit so single-bit pointers stay legal
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // CNT_W = clog2(MAX_BURST)+1
    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit scanning last_ptr+1, last_ptr+2, ... mod N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = ptr_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [PTR_W-1:0] pick,
    output logic             pick_valid
);

    always_comb begin
        int cand;
        cand       = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_ptr) + k) % N;
            if (!pick_valid && req[PTR_W'(cand)]) begin
                pick       = PTR_W'(cand);
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded sharing of the async_fifo write port among N requesters.
// Optional per-requester beat and stall counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [N-1:0]        req,
    input  logic [N*DW-1:0]     req_data,
    output logic [N-1:0]        ack,
    output logic [N-1:0]        gnt,
    output logic                busy,
    input  logic                wfull,
    output logic                winc,
    output logic [DW-1:0]       wdata
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [N*STAT_W-1:0] stat_cnt,
    output logic [STAT_W-1:0]   stall_cycles
`endif
);

    localparam int PTR_W = ptr_w(N);
    localparam int CNT_W = cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(N - 1);

    arb_state_e           state_q, state_d;
    logic [N-1:0]         gnt_q, gnt_d;
    logic [PTR_W-1:0]     last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [N-1:0][DW-1:0] req_vec;
    logic [PTR_W-1:0]     pick;
    logic                 pick_valid;
    logic                 granted;
    logic                 req_g;

    assign req_vec = req_data;
    assign granted = (state_q == GRANT);
    // last_ptr is loaded with the pick on every grant, so it doubles as the granted index
    assign req_g   = req[last_ptr_q];

    rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
        .req        (req),
        .last_ptr   (last_ptr_q),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    always_comb begin
        winc  = granted & req_g & ~wfull;
        wdata = granted ? req_vec[last_ptr_q] : '0;
        ack   = winc ? gnt_q : '0;
        gnt   = gnt_q;
        busy  = granted;
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_ptr_d = last_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = GRANT;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    last_ptr_d  = pick;
                    beat_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (winc) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else if (!req_g) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                end
                // wfull with req held: everything frozen, no timeout
            end
            default: ;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_ptr_q <= PTR_RST;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_ptr_q <= last_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [N-1:0][STAT_W-1:0] stat_q, stat_d;
    logic [STAT_W-1:0]        stall_q, stall_d;

    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < N; i++) begin
            if (ack[i] && (stat_q[i] != '1)) stat_d[i] = stat_q[i] + STAT_W'(1);
        end
        stall_d = stall_q;
        if (granted && req_g && wfull && (stall_q != '1)) stall_d = stall_q + STAT_W'(1);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            stat_q  <= '0;
            stall_q <= '0;
        end else begin
            stat_q  <= stat_d;
            stall_q <= stall_d;
        end
    end

    assign stat_cnt     = stat_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed requester traffic, monitor checks each FIFO write.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic              wclk = 1'b0;
    logic              wrst_n;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      ack;
    logic [N-1:0]      gnt;
    logic              busy;
    logic              wfull;
    logic              winc;
    logic [DW-1:0]     wdata;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*16-1:0]   stat_cnt;
    logic [15:0]       stall_cycles;
`endif

    fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(4)) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .gnt      (gnt),
        .busy     (busy),
        .wfull    (wfull),
        .winc     (winc),
        .wdata    (wdata)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_cnt     (stat_cnt),
        .stall_cycles (stall_cycles)
`endif
    );

    initial forever #5 wclk = ~wclk;

    typedef struct {
        int          id;
        logic [7:0]  d;
    } exp_t;

    exp_t        exp_q[$];
    int          wr_cyc[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  rmem[N][64];
    int          rhead[N];
    int          rtail[N];
    logic [N-1:0] ack_s = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wclk);
        #2;
    endtask

    task automatic push_req(input int i, input logic [7:0] d);
        rmem[i][rtail[i]] = d;
        rtail[i]++;
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        exp_t e;
        e.id = i;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int maxc);
        for (int k = 0; k < maxc; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge wclk);
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        tick(4);
    endtask

    task automatic chk_gap(input string name, input int a, input int b, input int expd);
        if (wr_cyc.size() > b) chk(name, wr_cyc[b] - wr_cyc[a], expd);
        else chk(name, wr_cyc.size(), b + 1);
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        tick(2);
        wrst_n = 1'b1;
        tick(1);
        wr_cyc.delete();
    endtask

    initial forever begin
        @(posedge wclk);
        cyc++;
    end

    // requester model: hold req/data until the beat is seen acked, then advance
    initial begin
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        forever begin
            @(posedge wclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ack_s[i] && rhead[i] < rtail[i]) rhead[i]++;
                req[i] = (rhead[i] < rtail[i]);
                req_data[i*DW +: DW] = req[i] ? rmem[i][rhead[i]] : 8'h00;
            end
        end
    end

    // monitor: every write the DUT commits is popped against the scoreboard
    initial forever begin
        exp_t e;
        @(negedge wclk);
        ack_s = wrst_n ? ack : '0;
        if (wrst_n && gnt == '0)
            chk("idle_quiet", {23'd0, winc, ack, wdata}, 32'd0);
        if (wrst_n && winc) begin
            wr_cyc.push_back(cyc);
            chk("no_winc_when_full", {31'd0, wfull}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {24'd0, wdata}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wdata", {24'd0, wdata}, {24'd0, e.d});
                chk("ack_id", {28'd0, ack}, 32'd1 << e.id);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst_n = 1'b0;
        wfull  = 1'b0;
        tick(5);
        chk("rst_gnt", {28'd0, gnt}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_winc", {31'd0, winc}, 0);
        chk("rst_ack", {28'd0, ack}, 0);
        chk("rst_wdata", {24'd0, wdata}, 0);
        wrst_n = 1'b1;
        tick(1);
        wr_cyc.delete();

        // 1: single requester, 5 beats: 4-beat burst, bubble, regrant
        for (int k = 1; k <= 5; k++) begin
            push_req(0, 8'(k));
            push_exp(0, 8'(k));
        end
        tick(1);
        @(negedge wclk);
        chk("t1_gnt_latency", {28'd0, gnt}, 0);
        @(negedge wclk);
        chk("t1_gnt", {28'd0, gnt}, 32'h1);
        chk("t1_busy", {31'd0, busy}, 1);
        wait_drain("t1_drain", 100);
        chk_gap("t1_burst_span", 0, 3, 3);
        chk_gap("t1_bubble", 3, 4, 2);

        // 2: all four requesting: order 0,1,2,3 in bursts of 4, then one beat each
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 5; k++) push_req(i, 8'(16 * i + k));
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) push_exp(i, 8'(16 * i + k));
        for (int i = 0; i < N; i++) push_exp(i, 8'(16 * i + 4));
        wait_drain("t2_drain", 300);
        chk_gap("t2_bubble", 3, 4, 2);
        chk_gap("t2_four_bursts", 0, 15, 18);
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk($sformatf("t6_stat%0d", i), {16'd0, stat_cnt[i*16 +: 16]}, 5);
        chk("t6_stall_zero", {16'd0, stall_cycles}, 0);
`endif

        // 3: requester 2 stalled by wfull for 10 cycles after its first beat
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push_req(2, 8'hA0 + 8'(k));
            push_exp(2, 8'hA0 + 8'(k));
        end
        tick(1);
        @(negedge wclk);
        @(negedge wclk);
        chk("t3_gnt", {28'd0, gnt}, 32'h4);
        tick(1);
        wfull = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge wclk);
            chk("t3_stall", {26'd0, winc, ack, busy}, {26'd0, 1'b0, 4'b0000, 1'b1});
            chk("t3_stall_gnt", {28'd0, gnt}, 32'h4);
            tick(1);
        end
        wfull = 1'b0;
        wait_drain("t3_drain", 100);
        chk_gap("t3_stall_span", 0, 1, 11);
        chk_gap("t3_burst_rest", 1, 3, 2);
        chk_gap("t3_bubble", 3, 4, 2);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("t6_stall10", {16'd0, stall_cycles}, 10);
        chk("t6_stat2", {16'd0, stat_cnt[2*16 +: 16]}, 6);
`endif

        // 4: requester 1 releases after 2 beats; pending 3 is next
        do_reset();
        push_req(1, 8'h11); push_req(1, 8'h12);
        push_req(3, 8'h31); push_req(3, 8'h32);
        push_exp(1, 8'h11); push_exp(1, 8'h12);
        push_exp(3, 8'h31); push_exp(3, 8'h32);
        wait_drain("t4_drain", 100);
        chk_gap("t4_release_gap", 1, 2, 3);
        // with last_ptr=1, requester 2 beats requester 3
        do_reset();
        push_req(1, 8'h13); push_req(1, 8'h14);
        push_req(2, 8'h21);
        push_req(3, 8'h33);
        push_exp(1, 8'h13); push_exp(1, 8'h14);
        push_exp(2, 8'h21);
        push_exp(3, 8'h33);
        wait_drain("t4b_drain", 100);

        // 5: reset during beat 2 of requester 1's burst
        do_reset();
        for (int k = 0; k < 6; k++) push_req(1, 8'h40 + 8'(k));
        push_exp(1, 8'h40);
        tick(1);
        @(negedge wclk);
        @(negedge wclk);
        chk("t5_gnt", {28'd0, gnt}, 32'h2);
        tick(1);
        wrst_n = 1'b0;
        push_req(0, 8'h50);
        push_req(2, 8'h52);
        push_req(3, 8'h53);
        tick(1);
        wrst_n = 1'b1;
        push_exp(0, 8'h50);
        for (int k = 1; k < 5; k++) push_exp(1, 8'h40 + 8'(k));
        push_exp(2, 8'h52);
        push_exp(3, 8'h53);
        push_exp(1, 8'h45);
        @(negedge wclk);
        chk("t5_after_rst", {26'd0, winc, gnt, busy}, 0);
        @(negedge wclk);
        chk("t5_first_gnt", {28'd0, gnt}, 32'h1);
        wait_drain("t5_drain", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
